// File: rtl/pipeline_hazard_unit.sv
// rtl/pipeline_hazard_unit.sv - hazard detection, operand forwarding and stage control for the in-order pipeline
module pipeline_hazard_unit #(
  parameter int DEPTH      = 4,
  parameter int LOAD_STAGE = 2,
  parameter int REG_AW     = 5,
  parameter int SEL_W      = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic              id_wen,
  input  logic [REG_AW-1:0] id_waddr,
  input  logic              id_is_load,
  input  logic              id_is_branch,
  input  logic              branch_taken,
  input  logic              mem_busy,
  output logic              pc_en,
  output logic              flush_if,
  output logic [DEPTH-1:0]  stage_en,
  output logic [DEPTH-1:0]  stage_valid,
  output logic [SEL_W-1:0]  fwd_rs_sel,
  output logic [SEL_W-1:0]  fwd_rt_sel,
  output logic              stall_id,
  output logic [31:0]       stall_cnt
);

  // Destination records for stages 1..DEPTH-1; stage 0 (ID) comes straight from the id_* inputs.
  logic [DEPTH-1:1]  r_valid;
  logic [DEPTH-1:1]  r_wen;
  logic [DEPTH-1:1]  r_load;
  logic [REG_AW-1:0] r_waddr [1:DEPTH-1];
  logic [31:0]       r_stall_cnt;

  logic [DEPTH-1:0]  w_valid;
  logic [DEPTH-1:0]  w_wen;
  logic [DEPTH-1:0]  w_load;
  logic [REG_AW-1:0] w_waddr [0:DEPTH-1];
  logic [SEL_W-1:0]  w_rs_sel;
  logic [SEL_W-1:0]  w_rt_sel;
  logic              w_rs_hz;
  logic              w_rt_hz;
  logic              w_stall_id;
  logic              w_mem_wait;

  always_comb begin
    w_valid    = {r_valid, id_valid};
    w_wen      = {r_wen, id_wen};
    w_load     = {r_load, id_is_load};
    w_waddr[0] = id_waddr;
    for (int k = 1; k < DEPTH; k++) begin
      w_waddr[k] = r_waddr[k];
    end
  end

  // Scan oldest to youngest so the youngest matching producer wins.
  always_comb begin
    w_rs_sel = '0;
    w_rt_sel = '0;
    w_rs_hz  = 1'b0;
    w_rt_hz  = 1'b0;
    for (int k = DEPTH - 1; k >= 1; k--) begin
      if (id_rs_used && r_valid[k] && r_wen[k] && (r_waddr[k] != '0) && (r_waddr[k] == id_rs)) begin
        w_rs_sel = SEL_W'(k);
        w_rs_hz  = r_load[k] && (k < LOAD_STAGE);
      end
      if (id_rt_used && r_valid[k] && r_wen[k] && (r_waddr[k] != '0) && (r_waddr[k] == id_rt)) begin
        w_rt_sel = SEL_W'(k);
        w_rt_hz  = r_load[k] && (k < LOAD_STAGE);
      end
    end
  end

  assign w_stall_id = id_valid && (w_rs_hz || w_rt_hz);
  assign w_mem_wait = mem_busy && r_valid[LOAD_STAGE];

  always_comb begin
    stage_en = '1;
    if (w_mem_wait) begin
      for (int k = 0; k <= LOAD_STAGE; k++) begin
        stage_en[k] = 1'b0;
      end
    end else if (w_stall_id) begin
      stage_en[0] = 1'b0;
    end
  end

  assign pc_en       = !(w_mem_wait || w_stall_id);
  assign flush_if    = rst && id_valid && id_is_branch && branch_taken && !w_stall_id && !w_mem_wait;
  assign stage_valid = w_valid;
  assign fwd_rs_sel  = w_rs_sel;
  assign fwd_rt_sel  = w_rt_sel;
  assign stall_id    = w_stall_id;
  assign stall_cnt   = r_stall_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid     <= '0;
      r_wen       <= '0;
      r_load      <= '0;
      r_stall_cnt <= '0;
      for (int k = 1; k < DEPTH; k++) begin
        r_waddr[k] <= '0;
      end
    end else begin
      for (int k = 1; k < DEPTH; k++) begin
        if ((w_mem_wait && (k == LOAD_STAGE + 1)) || (!w_mem_wait && w_stall_id && (k == 1))) begin
          r_valid[k] <= 1'b0;
          r_wen[k]   <= 1'b0;
          r_load[k]  <= 1'b0;
          r_waddr[k] <= '0;
        end else if (!w_mem_wait || (k > LOAD_STAGE + 1)) begin
          r_valid[k] <= w_valid[k-1];
          r_wen[k]   <= w_wen[k-1];
          r_load[k]  <= w_load[k-1];
          r_waddr[k] <= w_waddr[k-1];
        end
      end
      if ((w_stall_id || w_mem_wait) && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// tb/tb_pipeline_hazard_unit.sv - directed self-checking bench for pipeline_hazard_unit (DEPTH=4, LOAD_STAGE=2)
module tb_pipeline_hazard_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_rs_used, id_rt_used, id_wen, id_is_load, id_is_branch, branch_taken, mem_busy;
  logic [4:0] id_rs, id_rt, id_waddr;
  logic       pc_en, flush_if, stall_id;
  logic [3:0] stage_en, stage_valid;
  logic [2:0] fwd_rs_sel, fwd_rt_sel;
  logic [31:0] stall_cnt;
  int total = 0;
  int bad = 0;

  pipeline_hazard_unit #(.DEPTH(4), .LOAD_STAGE(2), .REG_AW(5), .SEL_W(3)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_wen(id_wen), .id_waddr(id_waddr),
    .id_is_load(id_is_load), .id_is_branch(id_is_branch), .branch_taken(branch_taken),
    .mem_busy(mem_busy), .pc_en(pc_en), .flush_if(flush_if), .stage_en(stage_en),
    .stage_valid(stage_valid), .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
    .stall_id(stall_id), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic rsu, input logic [4:0] rt,
                       input logic rtu, input logic wen, input logic [4:0] wa, input logic ld,
                       input logic br, input logic tk);
    id_valid = v; id_rs = rs; id_rs_used = rsu; id_rt = rt; id_rt_used = rtu;
    id_wen = wen; id_waddr = wa; id_is_load = ld; id_is_branch = br; branch_taken = tk;
    #1;
  endtask

  task automatic drain();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    mem_busy = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    mem_busy = 1'b0;
    drive(1, 3, 1, 4, 1, 1, 7, 0, 1, 1);
    total++; if (stage_valid[3:1] !== 3'b000) begin bad++; $display("FAIL rst_valid got=%b exp=000", stage_valid[3:1]); end
    total++; if (flush_if !== 1'b0) begin bad++; $display("FAIL rst_flush got=%b exp=0", flush_if); end
    total++; if ({pc_en, stage_en} !== 5'b11111) begin bad++; $display("FAIL rst_en got=%b exp=11111", {pc_en, stage_en}); end
    total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", stall_cnt); end
    tick();
    rst = 1'b1;
    drain();
  endtask

  task automatic test_forward();
    drive(1, 0, 0, 0, 0, 1, 3, 0, 0, 0);
    tick();
    drive(1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
    total++; if ({fwd_rs_sel, stall_id} !== {3'd1, 1'b0}) begin bad++; $display("FAIL fwd_k1 got=%0d/%b exp=1/0", fwd_rs_sel, stall_id); end
    tick();
    total++; if (fwd_rs_sel !== 3'd2) begin bad++; $display("FAIL fwd_k2 got=%0d exp=2", fwd_rs_sel); end
    tick();
    total++; if (fwd_rs_sel !== 3'd3) begin bad++; $display("FAIL fwd_k3 got=%0d exp=3", fwd_rs_sel); end
    tick();
    total++; if (fwd_rs_sel !== 3'd0) begin bad++; $display("FAIL fwd_gone got=%0d exp=0", fwd_rs_sel); end
    drain();
  endtask

  task automatic test_load_use();
    drive(1, 0, 0, 0, 0, 1, 4, 1, 0, 0);
    tick();
    drive(1, 0, 0, 4, 1, 0, 0, 0, 0, 0);
    total++; if ({stall_id, pc_en, stage_en} !== 6'b10_1110) begin bad++; $display("FAIL lu_stall got=%b exp=101110", {stall_id, pc_en, stage_en}); end
    tick();
    total++; if ({stage_valid[1], stall_id} !== 2'b00) begin bad++; $display("FAIL lu_bubble got=%b exp=00", {stage_valid[1], stall_id}); end
    total++; if (fwd_rt_sel !== 3'd2) begin bad++; $display("FAIL lu_fwd got=%0d exp=2", fwd_rt_sel); end
    total++; if (stall_cnt !== 32'd1) begin bad++; $display("FAIL lu_cnt got=%0d exp=1", stall_cnt); end
    drain();
  endtask

  task automatic test_priority();
    drive(1, 0, 0, 0, 0, 1, 5, 0, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 1, 5, 0, 0, 0);
    tick();
    drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    total++; if (fwd_rs_sel !== 3'd1) begin bad++; $display("FAIL prio_young got=%0d exp=1", fwd_rs_sel); end
    drive(1, 5, 0, 5, 0, 0, 0, 0, 0, 0);
    total++; if ({fwd_rs_sel, fwd_rt_sel} !== 6'd0) begin bad++; $display("FAIL prio_unused got=%0d/%0d exp=0/0", fwd_rs_sel, fwd_rt_sel); end
    drain();
    drive(1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    tick();
    drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    total++; if (fwd_rs_sel !== 3'd0) begin bad++; $display("FAIL prio_r0 got=%0d exp=0", fwd_rs_sel); end
    drain();
  endtask

  task automatic test_mem_wait();
    drive(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 1, 6, 1, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    mem_busy = 1'b1;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 1; c <= 3; c++) begin
      total++; if ({pc_en, stage_en} !== 5'b0_1000) begin bad++; $display("FAIL mw_en_c%0d got=%b exp=01000", c, {pc_en, stage_en}); end
      total++; if (stage_valid[3] !== (c == 1)) begin bad++; $display("FAIL mw_wb_c%0d got=%b exp=%b", c, stage_valid[3], c == 1); end
      tick();
    end
    mem_busy = 1'b0;
    #1;
    total++; if ({pc_en, stage_en, stall_cnt} !== {5'b1_1111, 32'd4}) begin bad++; $display("FAIL mw_release got=%b cnt=%0d exp=11111 cnt=4", {pc_en, stage_en}, stall_cnt); end
    tick();
    total++; if (stage_valid[3] !== 1'b1) begin bad++; $display("FAIL mw_load_wb got=%b exp=1", stage_valid[3]); end
    drain();
  endtask

  task automatic test_branch();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    total++; if (flush_if !== 1'b1) begin bad++; $display("FAIL br_flush got=%b exp=1", flush_if); end
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    total++; if (flush_if !== 1'b0) begin bad++; $display("FAIL br_once got=%b exp=0", flush_if); end
    drain();
    drive(1, 0, 0, 0, 0, 1, 7, 1, 0, 0);
    tick();
    drive(1, 7, 1, 0, 0, 0, 0, 0, 1, 1);
    total++; if ({stall_id, flush_if} !== 2'b10) begin bad++; $display("FAIL br_stalled got=%b exp=10", {stall_id, flush_if}); end
    tick();
    total++; if ({stall_id, flush_if, fwd_rs_sel} !== {2'b01, 3'd2}) begin bad++; $display("FAIL br_release got=%b/%0d exp=01/2", {stall_id, flush_if}, fwd_rs_sel); end
    total++; if (stall_cnt !== 32'd5) begin bad++; $display("FAIL br_cnt got=%0d exp=5", stall_cnt); end
    drain();
  endtask

  task automatic test_back_to_back();
    drive(1, 0, 0, 0, 0, 1, 9, 1, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 1, 8, 1, 0, 0);
    tick();
    mem_busy = 1'b1;
    drive(1, 8, 1, 0, 0, 0, 0, 0, 1, 1);
    total++; if ({stall_id, pc_en, stage_en, flush_if} !== 7'b1_0_1000_0) begin bad++; $display("FAIL both_en got=%b exp=1010000", {stall_id, pc_en, stage_en, flush_if}); end
    tick();
    mem_busy = 1'b0;
    #1;
    total++; if (stall_cnt !== 32'd6) begin bad++; $display("FAIL both_cnt got=%0d exp=6", stall_cnt); end
    total++; if ({stall_id, stage_en} !== 5'b1_1110) begin bad++; $display("FAIL both_hold got=%b exp=11110", {stall_id, stage_en}); end
    drain();
  endtask

  task automatic test_async_reset();
    drive(1, 0, 0, 0, 0, 1, 3, 0, 0, 0);
    tick();
    tick();
    drive(1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
    #2;
    rst = 1'b0;
    #1;
    total++; if (stage_valid !== 4'b0001) begin bad++; $display("FAIL ar_valid got=%b exp=0001", stage_valid); end
    total++; if ({fwd_rs_sel, fwd_rt_sel, pc_en} !== 7'b000_000_1) begin bad++; $display("FAIL ar_fwd got=%0d/%0d pc=%b exp=0/0 pc=1", fwd_rs_sel, fwd_rt_sel, pc_en); end
    total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL ar_cnt got=%0d exp=0", stall_cnt); end
    tick();
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_priority();
    test_mem_wait();
    test_branch();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
